apb_master_ctrl: RTL and testbench



---
 rtl/apb_pkg.sv | 23 ++
 rtl/apb_addr_decoder.sv | 25 ++
 rtl/apb_master_ctrl.sv | 143 ++++++++++++++
 tb/tb_apb_master_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and sizing helpers for the APB master controller family.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DECERR = 2'd3
  } apb_state_e;

  localparam int APB_PROT_WIDTH = 3;

  // Width of the slave index; a single slave still gets one index bit.
  function automatic int sel_bits(input int num_slaves);
    return (num_slaves <= 1) ? 1 : $clog2(num_slaves);
  endfunction

  // Width of the ACCESS wait counter; a disabled timeout still gets one bit.
  function automatic int cnt_bits(input int timeout);
    return (timeout <= 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Turns a slave index into a one-hot PSEL pattern and flags indexes with no slave behind them.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int SEL_BITS   = sel_bits(NUM_SLAVES)
) (
  input  logic [SEL_BITS-1:0]   idx,
  output logic [NUM_SLAVES-1:0] sel,
  output logic                  legal
);

  // Match the index against every populated slave slot; no match means a decode error.
  always_comb begin
    sel   = '0;
    legal = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx == SEL_BITS'(i)) begin
        sel[i] = 1'b1;
        legal  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB4 master: valid/ready request side, multi-slave decode, back-to-back transfers,
// decode errors and a PREADY timeout, with a one-cycle response pulse.
module apb_master_ctrl
  import apb_pkg::*;
#(
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_SLAVES = 4,
  parameter  int TIMEOUT    = 16,
  localparam int STRB_WIDTH = DATA_WIDTH / 8,
  localparam int SEL_BITS   = sel_bits(NUM_SLAVES),
  localparam int CNT_BITS   = cnt_bits(TIMEOUT)
) (
  input  logic                             PCLK,
  input  logic                             PRESET,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic                             s_write,
  input  logic [ADDR_WIDTH-1:0]            s_addr,
  input  logic [DATA_WIDTH-1:0]            s_wdata,
  input  logic [STRB_WIDTH-1:0]            s_strb,
  input  logic [APB_PROT_WIDTH-1:0]        s_prot,
  output logic                             r_valid,
  output logic [DATA_WIDTH-1:0]            r_rdata,
  output logic                             r_err,
  output logic [NUM_SLAVES-1:0]            PSEL,
  output logic                             PENABLE,
  output logic                             PWRITE,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  output logic [STRB_WIDTH-1:0]            PSTRB,
  output logic [APB_PROT_WIDTH-1:0]        PPROT,
  input  logic [NUM_SLAVES-1:0]            PREADY,
  input  logic [NUM_SLAVES-1:0]            PSLVERR,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA
);

  apb_state_e            state;
  logic [CNT_BITS-1:0]   wait_cnt;
  logic [NUM_SLAVES-1:0] dec_sel;
  logic                  dec_legal;
  logic                  sel_ready;
  logic                  sel_err;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic                  accept;
  logic                  timeout_hit;

  apb_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .SEL_BITS   (SEL_BITS)
  ) u_decoder (
    .idx   (s_addr[ADDR_WIDTH-1 -: SEL_BITS]),
    .sel   (dec_sel),
    .legal (dec_legal)
  );

  // The registered one-hot PSEL doubles as the mux select for the addressed slave's response.
  always_comb begin
    sel_ready = |(PREADY & PSEL);
    sel_err   = |(PSLVERR & PSEL);
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (PSEL[i]) begin
        sel_rdata = sel_rdata | PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign s_ready     = (state == IDLE) || ((state == ACCESS) && sel_ready);
  assign accept      = s_valid && s_ready;
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CNT_BITS'(TIMEOUT - 1));

  // Transfer sequencer; a new request accepted in the completing ACCESS cycle overrides the return to IDLE.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state    <= IDLE;
      wait_cnt <= '0;
      PSEL     <= '0;
      PENABLE  <= 1'b0;
      PWRITE   <= 1'b0;
      PADDR    <= '0;
      PWDATA   <= '0;
      PSTRB    <= '0;
      PPROT    <= '0;
      r_valid  <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      case (state)
        IDLE: begin
        end
        SETUP: begin
          state    <= ACCESS;
          PENABLE  <= 1'b1;
          wait_cnt <= '0;
        end
        ACCESS: begin
          if (sel_ready) begin
            r_valid <= 1'b1;
            r_err   <= sel_err;
            r_rdata <= PWRITE ? '0 : sel_rdata;
            state   <= IDLE;
            PSEL    <= '0;
            PENABLE <= 1'b0;
          end else if (timeout_hit) begin
            r_valid <= 1'b1;
            r_err   <= 1'b1;
            state   <= IDLE;
            PSEL    <= '0;
            PENABLE <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + CNT_BITS'(1);
          end
        end
        DECERR: begin
          r_valid <= 1'b1;
          r_err   <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (accept) begin
        if (dec_legal) begin
          state   <= SETUP;
          PSEL    <= dec_sel;
          PENABLE <= 1'b0;
          PWRITE  <= s_write;
          PADDR   <= s_addr;
          PWDATA  <= s_wdata;
          PSTRB   <= s_write ? s_strb : '0;
          PPROT   <= s_prot;
        end else begin
          // Bus outputs are left untouched so an undecodable request causes no bus activity.
          state <= DECERR;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Testbench for apb_master_ctrl: a per-cycle expectation timeline is built from transaction-level
// rules (SETUP, ACCESS for wait states + 1 cycles, response pulse on the next cycle), then replayed.
module tb_apb_master_ctrl;

  localparam int NS    = 3;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int TO    = 16;
  localparam int LAST  = 90;
  localparam int DEPTH = 128;

  logic             PCLK = 1'b0;
  logic             PRESET;
  logic             s_valid;
  logic             s_ready;
  logic             s_write;
  logic [AW-1:0]    s_addr;
  logic [DW-1:0]    s_wdata;
  logic [3:0]       s_strb;
  logic [2:0]       s_prot;
  logic             r_valid;
  logic [DW-1:0]    r_rdata;
  logic             r_err;
  logic [NS-1:0]    PSEL;
  logic             PENABLE;
  logic             PWRITE;
  logic [AW-1:0]    PADDR;
  logic [DW-1:0]    PWDATA;
  logic [3:0]       PSTRB;
  logic [2:0]       PPROT;
  logic [NS-1:0]    PREADY;
  logic [NS-1:0]    PSLVERR;
  logic [NS*DW-1:0] PRDATA;

  apb_master_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_SLAVES (NS),
    .TIMEOUT    (TO)
  ) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_write (s_write),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_strb  (s_strb),
    .s_prot  (s_prot),
    .r_valid (r_valid),
    .r_rdata (r_rdata),
    .r_err   (r_err),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PSTRB   (PSTRB),
    .PPROT   (PPROT),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR),
    .PRDATA  (PRDATA)
  );

  // Free-running 10-unit clock.
  always #5 PCLK = ~PCLK;

  logic             st_reset   [DEPTH];
  logic             st_valid   [DEPTH];
  logic             st_write   [DEPTH];
  logic [AW-1:0]    st_addr    [DEPTH];
  logic [DW-1:0]    st_wdata   [DEPTH];
  logic [3:0]       st_strb    [DEPTH];
  logic [2:0]       st_prot    [DEPTH];
  logic [NS-1:0]    st_pready  [DEPTH];
  logic [NS-1:0]    st_pslverr [DEPTH];
  logic [NS*DW-1:0] st_prdata  [DEPTH];

  logic [NS-1:0]    e_psel   [DEPTH];
  logic             e_pen    [DEPTH];
  logic             e_sready [DEPTH];
  logic             e_rvalid [DEPTH];
  logic             e_rerr   [DEPTH];
  logic [DW-1:0]    e_rdata  [DEPTH];
  logic             e_busck  [DEPTH];
  logic [AW-1:0]    e_paddr  [DEPTH];
  logic             e_pwrite [DEPTH];
  logic [DW-1:0]    e_pwdata [DEPTH];
  logic [3:0]       e_pstrb  [DEPTH];
  logic [2:0]       e_pprot  [DEPTH];

  int cyc         = 0;
  int vectors     = 0;
  int miscompares = 0;

  function automatic logic [NS-1:0] oneHot(input logic [AW-1:0] addr);
    return NS'(3'b001 << addr[AW-1 -: 2]);
  endfunction

  task automatic initDefaults();
    logic [NS*DW-1:0] junk;
    junk = {32'hBBBB_2222, 32'hBBBB_1111, 32'hBBBB_0000};
    for (int c = 0; c < DEPTH; c++) begin
      st_reset[c]   = 1'b0;
      st_valid[c]   = 1'b0;
      st_write[c]   = 1'b0;
      st_addr[c]    = '0;
      st_wdata[c]   = '0;
      st_strb[c]    = '0;
      st_prot[c]    = '0;
      st_pready[c]  = '0;
      st_pslverr[c] = '0;
      st_prdata[c]  = junk;
      e_psel[c]     = '0;
      e_pen[c]      = 1'b0;
      e_sready[c]   = 1'b1;
      e_rvalid[c]   = 1'b0;
      e_rerr[c]     = 1'b0;
      e_rdata[c]    = '0;
      e_busck[c]    = 1'b0;
      e_paddr[c]    = '0;
      e_pwrite[c]   = 1'b0;
      e_pwdata[c]   = '0;
      e_pstrb[c]    = '0;
      e_pprot[c]    = '0;
    end
  endtask

  task automatic setBus(input int c, input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [3:0] strb, input logic [2:0] prot);
    e_busck[c]  = 1'b1;
    e_paddr[c]  = addr;
    e_pwrite[c] = wr;
    e_pwdata[c] = wdata;
    e_pstrb[c]  = wr ? strb : 4'h0;
    e_pprot[c]  = prot;
  endtask

  // One legal transfer: request offered from cycle vfrom, accepted in cycle a.
  task automatic schedXfer(input int vfrom, input int a, input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [3:0] strb, input logic [2:0] prot,
                           input int ws, input bit tmo, input logic slverr, input logic [DW-1:0] rdata);
    logic [NS-1:0] oh;
    int idx;
    int nacc;
    int r;
    bit done;
    oh   = oneHot(addr);
    idx  = int'(addr[AW-1 -: 2]);
    nacc = tmo ? TO : ws + 1;
    for (int c = vfrom; c <= a; c++) begin
      st_valid[c] = 1'b1;
      st_write[c] = wr;
      st_addr[c]  = addr;
      st_wdata[c] = wdata;
      st_strb[c]  = strb;
      st_prot[c]  = prot;
    end
    e_psel[a+1]   = oh;
    e_pen[a+1]    = 1'b0;
    e_sready[a+1] = 1'b0;
    setBus(a + 1, wr, addr, wdata, strb, prot);
    for (int i = 0; i < nacc; i++) begin
      int c;
      c    = a + 2 + i;
      done = !tmo && (i == ws);
      e_psel[c]     = oh;
      e_pen[c]      = 1'b1;
      e_sready[c]   = done;
      st_pready[c]  = done ? {NS{1'b1}} : ~oh;
      st_pslverr[c] = ~oh | ((done && slverr) ? oh : '0);
      st_prdata[c][idx*DW +: DW] = done ? rdata : (32'hFACE_0000 | 32'(c));
      setBus(c, wr, addr, wdata, strb, prot);
    end
    r = a + 2 + nacc;
    e_rvalid[r] = 1'b1;
    e_rerr[r]   = tmo ? 1'b1 : slverr;
    e_rdata[r]  = (tmo || wr) ? '0 : rdata;
    setBus(r, wr, addr, wdata, strb, prot);
  endtask

  // Undecodable request accepted in cycle a: one dead cycle, then an error response.
  task automatic schedDecerr(input int a, input logic [AW-1:0] addr);
    st_valid[a]   = 1'b1;
    st_write[a]   = 1'b1;
    st_addr[a]    = addr;
    st_wdata[a]   = 32'h0BAD_0BAD;
    st_strb[a]    = 4'hF;
    st_pready[a+1] = {NS{1'b1}};
    e_sready[a+1] = 1'b0;
    e_rvalid[a+2] = 1'b1;
    e_rerr[a+2]   = 1'b1;
    e_rdata[a+2]  = '0;
  endtask

  task automatic applyStimulus(input int c);
    PRESET  = st_reset[c];
    s_valid = st_valid[c];
    s_write = st_write[c];
    s_addr  = st_addr[c];
    s_wdata = st_wdata[c];
    s_strb  = st_strb[c];
    s_prot  = st_prot[c];
    PREADY  = st_pready[c];
    PSLVERR = st_pslverr[c];
    PRDATA  = st_prdata[c];
  endtask

  task automatic compareField(input string nm, input int c, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", nm, c, act, expv);
    end
  endtask

  task automatic checkOutput(input int c);
    compareField("psel", c, 64'(PSEL), 64'(e_psel[c]));
    compareField("penable", c, 64'(PENABLE), 64'(e_pen[c]));
    compareField("s_ready", c, 64'(s_ready), 64'(e_sready[c]));
    compareField("r_valid", c, 64'(r_valid), 64'(e_rvalid[c]));
    compareField("r_err", c, 64'(r_err), 64'(e_rerr[c]));
    compareField("r_rdata", c, 64'(r_rdata), 64'(e_rdata[c]));
    if (e_busck[c]) begin
      compareField("paddr", c, 64'(PADDR), 64'(e_paddr[c]));
      compareField("pwrite", c, 64'(PWRITE), 64'(e_pwrite[c]));
      compareField("pwdata", c, 64'(PWDATA), 64'(e_pwdata[c]));
      compareField("pstrb", c, 64'(PSTRB), 64'(e_pstrb[c]));
      compareField("pprot", c, 64'(PPROT), 64'(e_pprot[c]));
    end
    case (c)
      7:  compareField("pin_wr_psel", c, 64'(PSEL), 64'h2);
      8:  compareField("pin_wr_resp", c, 64'({r_valid, r_err}), 64'h2);
      15: compareField("pin_rd_pstrb", c, 64'(PSTRB), 64'h0);
      18: compareField("pin_rd_data", c, 64'(r_rdata), 64'h1234_5678);
      33: compareField("pin_decerr", c, 64'({r_valid, r_err, PSEL}), 64'h18);
      53: compareField("pin_tmo_pen", c, 64'(PENABLE), 64'h1);
      54: compareField("pin_tmo_resp", c, 64'({r_valid, r_err, PENABLE}), 64'h6);
      76: compareField("pin_rst_paddr", c, 64'(PADDR), 64'h0);
      default: begin
      end
    endcase
  endtask

  // Compare every cycle after the first edge, away from the rising edge.
  always @(negedge PCLK) begin
    if (cyc >= 1 && cyc <= LAST) begin
      checkOutput(cyc);
    end
  end

  // Build the timeline, then replay it one cycle at a time.
  initial begin
    initDefaults();
    for (int c = 0; c <= 2; c++) st_reset[c] = 1'b1;
    for (int c = 1; c <= 5; c++) setBus(c, 1'b0, '0, '0, 4'h0, 3'h0);
    // zero-wait write to slave 1
    schedXfer(5, 5, 1'b1, 32'h4000_0010, 32'hDEAD_BEEF, 4'hF, 3'b010, 0, 1'b0, 1'b0, 32'h7777_7777);
    // read from slave 2 with three wait states
    schedXfer(12, 12, 1'b0, 32'h8000_0004, 32'h0000_1111, 4'hF, 3'b001, 3, 1'b0, 1'b0, 32'h1234_5678);
    // back-to-back writes, second request held through the first one's SETUP
    schedXfer(22, 22, 1'b1, 32'h0000_0100, 32'hCAFE_0001, 4'hF, 3'b000, 0, 1'b0, 1'b0, 32'h6666_6666);
    schedXfer(23, 24, 1'b1, 32'h4000_0200, 32'hCAFE_0002, 4'b0101, 3'b100, 0, 1'b0, 1'b0, 32'h6666_6666);
    // index 3 has no slave behind it
    schedDecerr(31, 32'hC000_0000);
    // slave 2 never answers
    schedXfer(36, 36, 1'b0, 32'h8000_0008, 32'h0, 4'h0, 3'b011, 0, 1'b1, 1'b0, 32'h0);
    // slave error on a one-wait write
    schedXfer(58, 58, 1'b1, 32'h0000_0040, 32'h0102_0304, 4'b1000, 3'b010, 1, 1'b0, 1'b1, 32'h5555_AAAA);
    // zero-wait read from slave 1
    schedXfer(65, 65, 1'b0, 32'h4000_0008, 32'h0, 4'h3, 3'b000, 0, 1'b0, 1'b0, 32'hA5A5_0F0F);
    // reset lands in the second ACCESS cycle and kills the transfer
    schedXfer(72, 72, 1'b0, 32'h4000_0044, 32'h0, 4'h0, 3'b111, 3, 1'b0, 1'b0, 32'h9999_9999);
    st_reset[75] = 1'b1;
    for (int c = 76; c <= 80; c++) begin
      e_psel[c]    = '0;
      e_pen[c]     = 1'b0;
      e_sready[c]  = 1'b1;
      e_rvalid[c]  = 1'b0;
      e_rerr[c]    = 1'b0;
      e_rdata[c]   = '0;
      st_pready[c] = '0;
      setBus(c, 1'b0, '0, '0, 4'h0, 3'h0);
    end
    // operation resumes after the reset
    schedXfer(82, 82, 1'b1, 32'h8000_0020, 32'h1357_9BDF, 4'hC, 3'b001, 0, 1'b0, 1'b0, 32'h4444_4444);

    applyStimulus(0);
    while (cyc < LAST) begin
      @(posedge PCLK);
      #1;
      cyc++;
      applyStimulus(cyc);
    end
    @(negedge PCLK);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
